// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter: ALU opcode encodings,
// the arbiter FSM state encoding and the latched-request record.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_SLL = 5'd4;
    localparam logic [OP_W-1:0] OP_SRA = 5'd5;
    localparam logic [OP_W-1:0] OP_MAX = OP_SRA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Operation captured from the granted requester at acceptance.
    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [OP_W-1:0]   op;
        logic [OP_W-1:0]   shamt;
        logic              id;
    } req_t;

    function automatic logic op_is_err(input logic [OP_W-1:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU shared by both requesters.
// Ports:
//   op_a, op_b : operands
//   op         : opcode (ADD, SUB, AND, OR, SLL, SRA); others yield result 0
//   shamt      : shift amount for SLL/SRA (applied to op_a)
//   result     : operation result
//   is_ne      : (op_a - op_b) != 0
//   is_lt      : signed op_a < op_b, derived from op_a - op_b
//   ovf        : SUB overflow for op SUB, ADD overflow for every other op
// -----------------------------------------------------------------------------
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   shamt,
    output logic [DATA_W-1:0] result,
    output logic              is_ne,
    output logic              is_lt,
    output logic              ovf
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;

    // NOTE: combinational blocks use blocking '=' and assign every output
    // up front, so no path through the block leaves a value unassigned and
    // no latch is inferred.
    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        add_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]);
        sub_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);

        is_ne = |diff;
        // Signed compare: sign of the difference, corrected when it overflowed.
        is_lt = diff[DATA_W-1] ^ sub_ovf;
        ovf   = (op == OP_SUB) ? sub_ovf : add_ovf;

        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_SLL:  result = op_a << shamt;
            OP_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way grant with a last-grant pointer.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   en             : arbitration allowed this cycle (arbiter idle)
//   valid0, valid1 : requester valids
//   gnt0, gnt1     : one-hot (or zero) grant, combinational on the valids
// RR_EN = 1 alternates on ties; RR_EN = 0 always favours requester 0.
// The pointer resets to 1 so requester 0 wins the first tie, and it moves only
// when a grant is given (grant == acceptance, since ready is the grant).
// -----------------------------------------------------------------------------
module rr_pick2 #(
    parameter int unsigned RR_EN = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (en) begin
            if (valid0 && valid1) begin
                if ((RR_EN != 0) && (last_q == 1'b0)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = valid0;
                gnt1 = valid1;
            end
        end

        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Arbitrates two requesters onto a single shared ALU. One operation is in
// flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (hold response
// until rsp_ready).
// Ports:
//   clock, reset               : rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready    : request handshake for requester N (0, 1)
//   reqN_opA, reqN_opB         : 32-bit operands
//   reqN_op, reqN_shamt        : opcode and shift amount
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : requester that issued the response
//   rsp_result                 : ALU result (0 for illegal opcodes)
//   rsp_ne, rsp_lt, rsp_ovf    : flags from the same operation
//   rsp_err                    : opcode was above OP_MAX
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_opA,
    input  logic [DATA_W-1:0] req0_opB,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [OP_W-1:0]   req0_shamt,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_opA,
    input  logic [DATA_W-1:0] req1_opB,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [OP_W-1:0]   req1_shamt,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_ne,
    output logic              rsp_lt,
    output logic              rsp_ovf,
    output logic              rsp_err
);

    state_e            state_q,  state_d;
    req_t              req_q,    req_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ne_q,     ne_d;
    logic              lt_q,     lt_d;
    logic              ovf_q,    ovf_d;
    logic              err_q,    err_d;

    logic              gnt0;
    logic              gnt1;
    logic              arb_en;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ne;
    logic              alu_lt;
    logic              alu_ovf;

    // Gating with reset keeps both readies low while reset is held, even
    // though the state register already reads IDLE.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    rr_pick2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .clock  (clock),
        .reset  (reset),
        .en     (arb_en),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    alu u_alu (
        .op_a   (req_q.op_a),
        .op_b   (req_q.op_b),
        .op     (req_q.op),
        .shamt  (req_q.shamt),
        .result (alu_result),
        .is_ne  (alu_ne),
        .is_lt  (alu_lt),
        .ovf    (alu_ovf)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        result_d = result_q;
        ne_d     = ne_q;
        lt_d     = lt_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt1) begin
                    req_d.op_a  = req1_opA;
                    req_d.op_b  = req1_opB;
                    req_d.op    = req1_op;
                    req_d.shamt = req1_shamt;
                    req_d.id    = 1'b1;
                    state_d     = ST_EXEC;
                end else if (gnt0) begin
                    req_d.op_a  = req0_opA;
                    req_d.op_b  = req0_opB;
                    req_d.op    = req0_op;
                    req_d.shamt = req0_shamt;
                    req_d.id    = 1'b0;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal opcodes never take anything from the ALU output.
                err_d    = op_is_err(req_q.op);
                result_d = err_d ? '0 : alu_result;
                ne_d     = !err_d && alu_ne;
                lt_d     = !err_d && alu_lt;
                ovf_d    = !err_d && alu_ovf;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            result_q <= '0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            result_q <= result_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Every rsp_* field comes straight from a register that only changes in
    // IDLE or EXEC, so the response is stable for as long as RESP is held.
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = req_q.id;
    assign rsp_result = result_q;
    assign rsp_ne     = ne_q;
    assign rsp_lt     = lt_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. Two instances share all inputs: one with
// round-robin grant, one with fixed priority. Inputs change on the falling
// edge; outputs are sampled on the falling edge (or 1 ns after it for the
// combinational readies).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req0_valid = 1'b0;
    logic [31:0] req0_opA   = '0;
    logic [31:0] req0_opB   = '0;
    logic [4:0]  req0_op    = '0;
    logic [4:0]  req0_shamt = '0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_opA   = '0;
    logic [31:0] req1_opB   = '0;
    logic [4:0]  req1_op    = '0;
    logic [4:0]  req1_shamt = '0;
    logic        rsp_ready  = 1'b1;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_ne, rsp_lt, rsp_ovf, rsp_err;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
    logic [31:0] fp_rsp_result;
    logic        fp_rsp_ne, fp_rsp_lt, fp_rsp_ovf, fp_rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    alu_arbiter #(.RR_EN(1)) dut_rr (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opA   (req0_opA),
        .req0_opB   (req0_opB),
        .req0_op    (req0_op),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opA   (req1_opA),
        .req1_opB   (req1_opB),
        .req1_op    (req1_op),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ne     (rsp_ne),
        .rsp_lt     (rsp_lt),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err)
    );

    alu_arbiter #(.RR_EN(0)) dut_fp (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (fp_req0_ready),
        .req0_opA   (req0_opA),
        .req0_opB   (req0_opB),
        .req0_op    (req0_op),
        .req0_shamt (req0_shamt),
        .req1_valid (req1_valid),
        .req1_ready (fp_req1_ready),
        .req1_opA   (req1_opA),
        .req1_opB   (req1_opB),
        .req1_op    (req1_op),
        .req1_shamt (req1_shamt),
        .rsp_valid  (fp_rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (fp_rsp_id),
        .rsp_result (fp_rsp_result),
        .rsp_ne     (fp_rsp_ne),
        .rsp_lt     (fp_rsp_lt),
        .rsp_ovf    (fp_rsp_ovf),
        .rsp_err    (fp_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return 32'({rsp_ne, rsp_lt, rsp_ovf, rsp_err});
    endfunction

    task automatic set_req(input logic id, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        if (id) begin
            req1_op = op; req1_opA = a; req1_opB = b; req1_shamt = sh; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_opA = a; req0_opB = b; req0_shamt = sh; req0_valid = 1'b1;
        end
    endtask

    // Overwrite operands after acceptance: the response must not depend on them.
    task automatic scramble();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opA = 32'hDEADBEEF; req0_opB = 32'h12345678; req0_op = 5'd3; req0_shamt = 5'd9;
        req1_opA = 32'hCAFEF00D; req1_opB = 32'h0BADF00D; req1_op = 5'd2; req1_shamt = 5'd17;
    endtask

    // One request through the full IDLE -> EXEC -> RESP sequence.
    // exp_flags = {ne, lt, ovf, err}.
    task automatic do_op(input string tag, input logic id, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clock);
        set_req(id, op, a, b, sh);
        #1;
        check({tag, " ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        check({tag, " other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
        @(negedge clock);
        scramble();
        check({tag, " exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clock);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " flags"}, flags(), 32'(exp_flags));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst req0_ready", 32'(req0_ready), 32'd0);
        check("rst req1_ready", 32'(req1_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_id", 32'(rsp_id), 32'd0);
        check("rst result", rsp_result, 32'd0);
        check("rst flags", flags(), 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    logic exp_rr [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Basic operations, including the ADD overflow boundary.
        do_op("add_ovf", 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 4'b1010);
        do_op("sub_neg", 1'b1, 5'd1, 32'd5, 32'd9, 5'd0, 32'hFFFF_FFFC, 4'b1100);
        do_op("sub_eq",  1'b1, 5'd1, 32'd9, 32'd9, 5'd0, 32'h0000_0000, 4'b0000);
        do_op("bad_op",  1'b0, 5'd7, 32'd3, 32'd4, 5'd0, 32'h0000_0000, 4'b0001);
        do_op("sra",     1'b1, 5'd5, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 4'b1100);
        do_op("sll",     1'b0, 5'd4, 32'd1, 32'd2, 5'd31, 32'h8000_0000, 4'b1100);
        do_op("or",      1'b0, 5'd3, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 4'b1000);
        do_op("and",     1'b1, 5'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0F00_0F00, 4'b1100);

        // Ties: pointer starts at 1 after reset. A valid that drops before
        // any clock edge must not move it.
        apply_reset();
        @(negedge clock);
        set_req(1'b1, 5'd0, 32'd10, 32'd10, 5'd0);
        #1;
        check("pulse req1_ready", 32'(req1_ready), 32'd1);
        #1;
        req1_valid = 1'b0;
        @(negedge clock);
        set_req(1'b0, 5'd0, 32'd1, 32'd1, 5'd0);
        set_req(1'b1, 5'd0, 32'd10, 32'd10, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("tie%0d rr_ready0", k), 32'(req0_ready), 32'(!exp_rr[k]));
            check($sformatf("tie%0d rr_ready1", k), 32'(req1_ready), 32'(exp_rr[k]));
            check($sformatf("tie%0d fp_ready0", k), 32'(fp_req0_ready), 32'd1);
            check($sformatf("tie%0d fp_ready1", k), 32'(fp_req1_ready), 32'd0);
            @(negedge clock);
            @(negedge clock);
            check($sformatf("tie%0d rr_id", k), 32'(rsp_id), 32'(exp_rr[k]));
            check($sformatf("tie%0d rr_result", k), rsp_result, exp_rr[k] ? 32'd20 : 32'd2);
            check($sformatf("tie%0d fp_id", k), 32'(fp_rsp_id), 32'd0);
            check($sformatf("tie%0d fp_result", k), fp_rsp_result, 32'd2);
            @(negedge clock);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: response held for 4+ cycles, pending req1 waits.
        @(negedge clock);
        rsp_ready = 1'b0;
        set_req(1'b0, 5'd0, 32'd2, 32'd3, 5'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        set_req(1'b1, 5'd0, 32'd100, 32'd1, 5'd0);
        #1;
        check("bp exec req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d result", i), rsp_result, 32'd5);
            check($sformatf("bp%0d id", i), 32'(rsp_id), 32'd0);
            check($sformatf("bp%0d readies", i), 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp release rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clock);
        #1;
        check("bp idle req1_ready", 32'(req1_ready), 32'd1);
        @(negedge clock);
        scramble();
        @(negedge clock);
        check("bp next rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp next id", 32'(rsp_id), 32'd1);
        check("bp next result", rsp_result, 32'd101);

        // Reset while EXEC: no response may appear for the discarded op.
        @(negedge clock);
        set_req(1'b0, 5'd0, 32'd1, 32'd2, 5'd0);
        @(negedge clock);
        scramble();
        reset = 1'b1;
        #1;
        check("rst_exec rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("rst_exec quiet%0d", i), 32'(rsp_valid), 32'd0);
        end
        do_op("after_rst", 1'b0, 5'd0, 32'd6, 32'd7, 5'd0, 32'd13, 4'b1100);

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
